// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
// Holds the responder state encoding, the default I/O address and a byte-merge helper.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StRdData,
    StWrHold
  } mem_state_e;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  // Wide enough for READ_LAT up to 7.
  localparam int unsigned CntW = 3;

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_val,
                                              input logic [15:0] new_val,
                                              input logic [1:0]  be);
    logic [15:0] res;
    res = old_val;
    if (be[1]) res[15:8] = new_val[15:8];
    if (be[0]) res[7:0]  = new_val[7:0];
    return res;
  endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port word array: synchronous byte-enabled write and synchronous registered read.
// The read register is cleared by reset; array contents are not.
module lc3_mem_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              we_i,
  input  logic [1:0]        be_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [15:0] mem_q [Depth];
  logic [15:0] rdata_q;

  always_ff @(posedge Clk) begin
    if (we_i) begin
      if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
      if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 SRAM-strobe responder: serves fetch/LDR/STR from an on-chip array and decodes one
// memory-mapped I/O word (switches on read, hex display on write).
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned READ_LAT = 1,  // legal range 1..7
  parameter logic [15:0] IO_ADDR  = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic        Mem_CE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        Data_valid,
  output logic [15:0] Hex_out
);

  localparam logic [CntW-1:0] LatLoad = CntW'(READ_LAT - 1);

  mem_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     hex_q, hex_d;
  logic [15:0]     sw_pend_q, sw_pend_d;
  logic            io_q;
  logic [15:0]     io_data_q;

  logic            start_rd;
  logic            rd_load;
  logic [15:0]     rd_addr;
  logic            arr_we;
  logic [1:0]      wr_be;
  logic [15:0]     arr_rdata;
  logic [ADDR_W-1:0] arr_addr;

  assign wr_be = {~Mem_UB, ~Mem_LB};

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    hex_d     = hex_q;
    sw_pend_d = sw_pend_q;
    start_rd  = 1'b0;
    rd_load   = 1'b0;
    rd_addr   = addr_q;
    arr_we    = 1'b0;

    if (Mem_CE) begin
      state_d = StIdle;
    end else if (!Mem_WE) begin
      // Write wins over read; only the first WE-low edge of a pulse commits.
      if (state_q != StWrHold) begin
        state_d = StWrHold;
        if (ADDR == IO_ADDR) begin
          hex_d = merge_bytes(hex_q, Data_from_CPU, wr_be);
        end else begin
          arr_we = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          start_rd = !Mem_OE;
        end
        StRdWait: begin
          if (Mem_OE) begin
            state_d = StIdle;
          end else if (ADDR != addr_q) begin
            start_rd = 1'b1;
          end else if (cnt_q == CntW'(1)) begin
            cnt_d   = '0;
            state_d = StRdData;
            rd_load = 1'b1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StRdData: begin
          if (Mem_OE) begin
            state_d = StIdle;
          end else if (ADDR != addr_q) begin
            start_rd = 1'b1;
          end
        end
        StWrHold: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    if (start_rd) begin
      addr_d    = ADDR;
      cnt_d     = LatLoad;
      sw_pend_d = Switches;
      if (READ_LAT == 1) begin
        state_d = StRdData;
        rd_load = 1'b1;
        rd_addr = ADDR;
      end else begin
        state_d = StRdWait;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      hex_q     <= '0;
      sw_pend_q <= '0;
      io_q      <= 1'b0;
      io_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      hex_q     <= hex_d;
      sw_pend_q <= sw_pend_d;
      if (rd_load) begin
        io_q      <= (rd_addr == IO_ADDR);
        io_data_q <= start_rd ? Switches : sw_pend_q;
      end
    end
  end

  assign arr_addr = arr_we ? ADDR[ADDR_W-1:0] : rd_addr[ADDR_W-1:0];

  lc3_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .Clk    (Clk),
    .Reset  (Reset),
    .we_i   (arr_we && Reset),
    .be_i   (wr_be),
    .re_i   (rd_load),
    .addr_i (arr_addr),
    .wdata_i(Data_from_CPU),
    .rdata_o(arr_rdata)
  );

  always_comb begin
    Data_valid  = (state_q == StRdData) && (ADDR == addr_q) && !Mem_OE && !Mem_CE && Mem_WE;
    Data_to_CPU = io_q ? io_data_q : arr_rdata;
    Hex_out     = hex_q;
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: two instances (READ_LAT=1 and READ_LAT=3) share one stimulus
// stream and are checked each cycle against a behavioural model, plus directed literal checks.
module tb_lc3_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, din, sw;
  logic        ce, ub, lb, oe, we;
  logic [15:0] dout1, dout3, hex1, hex3;
  logic        v1, v3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lc3_mem_responder #(.ADDR_W(10), .READ_LAT(1), .IO_ADDR(16'hFFFF)) u_dut1 (
    .Clk(clk), .Reset(rst), .ADDR(addr), .Data_from_CPU(din), .Mem_CE(ce), .Mem_UB(ub),
    .Mem_LB(lb), .Mem_OE(oe), .Mem_WE(we), .Switches(sw), .Data_to_CPU(dout1),
    .Data_valid(v1), .Hex_out(hex1)
  );

  lc3_mem_responder #(.ADDR_W(10), .READ_LAT(3), .IO_ADDR(16'hFFFF)) u_dut3 (
    .Clk(clk), .Reset(rst), .ADDR(addr), .Data_from_CPU(din), .Mem_CE(ce), .Mem_UB(ub),
    .Mem_LB(lb), .Mem_OE(oe), .Mem_WE(we), .Switches(sw), .Data_to_CPU(dout3),
    .Data_valid(v3), .Hex_out(hex3)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a read session remembers its address and how many edges it has aged.
  logic        m_act [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_snap [2];
  logic [15:0] m_data [2];
  int          m_age [2];
  logic        m_held;
  logic [15:0] m_hex;
  logic [15:0] m_mem [1024];
  bit          model_ok = 1'b0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] model_val(input int d);
    logic [15:0] a;
    a = m_addr[d];
    return (a == 16'hFFFF) ? m_snap[d] : m_mem[a[9:0]];
  endfunction

  function automatic logic exp_valid(input int d);
    return m_act[d] && (m_age[d] >= lat_of(d)) && (addr == m_addr[d]) && !oe && !ce && we;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    m_held = 1'b0;
    m_hex  = '0;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_addr[d] = '0; m_snap[d] = '0; m_data[d] = '0; m_age[d] = 0;
    end
  end

  always @(posedge clk) begin
    logic        was_held;
    logic [15:0] wa;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin m_act[d] = 1'b0; m_data[d] = '0; end
      m_hex  = '0;
      m_held = 1'b0;
    end else if (ce) begin
      for (int d = 0; d < 2; d++) m_act[d] = 1'b0;
      m_held = 1'b0;
    end else if (!we) begin
      if (!m_held) begin
        wa = addr;
        if (addr == 16'hFFFF) begin
          if (!ub) m_hex[15:8] = din[15:8];
          if (!lb) m_hex[7:0]  = din[7:0];
        end else begin
          if (!ub) m_mem[wa[9:0]][15:8] = din[15:8];
          if (!lb) m_mem[wa[9:0]][7:0]  = din[7:0];
        end
        m_held = 1'b1;
      end
      for (int d = 0; d < 2; d++) m_act[d] = 1'b0;
    end else begin
      was_held = m_held;
      m_held   = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (was_held || oe) begin
          m_act[d] = 1'b0;
        end else if (!m_act[d] || addr != m_addr[d]) begin
          m_act[d]  = 1'b1;
          m_addr[d] = addr;
          m_snap[d] = sw;
          m_age[d]  = 1;
          if (m_age[d] >= lat_of(d)) m_data[d] = model_val(d);
        end else if (m_age[d] < lat_of(d)) begin
          m_age[d]++;
          if (m_age[d] == lat_of(d)) m_data[d] = model_val(d);
        end
      end
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_data1",  dout1,    m_data[0]);
      check("cyc_data3",  dout3,    m_data[1]);
      check("cyc_valid1", 16'(v1),  16'(exp_valid(0)));
      check("cyc_valid3", 16'(v3),  16'(exp_valid(1)));
      check("cyc_hex1",   hex1,     m_hex);
      check("cyc_hex3",   hex3,     m_hex);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce = 1'b1; we = 1'b1; oe = 1'b1; ub = 1'b0; lb = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic u, input logic l);
    ce = 1'b0; we = 1'b0; oe = 1'b1; addr = a; din = d; ub = u; lb = l;
    cyc();
    idle();
    cyc();
  endtask

  task automatic rd(input logic [15:0] a, input int n);
    ce = 1'b0; we = 1'b1; oe = 1'b0; addr = a;
    repeat (n) cyc();
    idle();
    cyc();
  endtask

  task automatic check_both(input string name, input logic [15:0] exp);
    #2;
    check({name, "_d1"}, dout1, exp);
    check({name, "_d3"}, dout3, exp);
  endtask

  initial begin
    rst = 1'b0; addr = '0; din = '0; sw = '0;
    idle();
    repeat (2) cyc();
    rst = 1'b1;
    #2;
    check("rst_d1", dout1, 16'h0000);
    check("rst_v1", 16'(v1), 16'h0);
    check("rst_hex1", hex1, 16'h0000);
    check("rst_d3", dout3, 16'h0000);
    check("rst_v3", 16'(v3), 16'h0);
    check("rst_hex3", hex3, 16'h0000);

    // Full write, then latency of both instances.
    wr(16'h0003, 16'hBEEF, 1'b0, 1'b0);
    ce = 1'b0; we = 1'b1; oe = 1'b0; addr = 16'h0003;
    for (int k = 1; k <= 4; k++) begin
      #2;
      check($sformatf("lat1_valid_c%0d", k), 16'(v1), 16'(k >= 2));
      check($sformatf("lat3_valid_c%0d", k), 16'(v3), 16'(k >= 4));
      if (k >= 2) check("lat1_data", dout1, 16'hBEEF);
      if (k == 4) check("lat3_data", dout3, 16'hBEEF);
      cyc();
    end
    idle();
    cyc();

    // Byte enables.
    wr(16'h0005, 16'hAAAA, 1'b0, 1'b0);
    wr(16'h0005, 16'h1234, 1'b1, 1'b0);
    rd(16'h0005, 4);
    check_both("lb_only", 16'hAA34);
    wr(16'h0005, 16'hFFFF, 1'b1, 1'b1);
    rd(16'h0005, 4);
    check_both("no_bytes", 16'hAA34);

    // Held WE with stepping address commits once.
    wr(16'h0011, 16'h5A5A, 1'b0, 1'b0);
    ce = 1'b0; we = 1'b0; oe = 1'b1; addr = 16'h0010; din = 16'h7777;
    cyc();
    addr = 16'h0011;
    cyc();
    cyc();
    idle();
    cyc();
    rd(16'h0010, 4);
    check_both("held_we_first", 16'h7777);
    rd(16'h0011, 4);
    check_both("held_we_second", 16'h5A5A);

    // I/O word: switches read, hex write with byte enables, alias location untouched.
    wr(16'h03FF, 16'h1357, 1'b0, 1'b0);
    sw = 16'h00C3;
    rd(16'hFFFF, 4);
    sw = 16'h0099;
    check_both("io_read_hold", 16'h00C3);
    wr(16'hFFFF, 16'h0042, 1'b0, 1'b0);
    #2;
    check("hex_write1", hex1, 16'h0042);
    check("hex_write3", hex3, 16'h0042);
    wr(16'hFFFF, 16'h9900, 1'b0, 1'b1);
    #2;
    check("hex_ub1", hex1, 16'h9942);
    rd(16'h03FF, 4);
    check_both("io_alias", 16'h1357);

    // Address change during RD_WAIT, then during RD_DATA.
    ce = 1'b0; we = 1'b1; oe = 1'b0; addr = 16'h0003;
    cyc();
    cyc();
    addr = 16'h0005;
    for (int k = 1; k <= 4; k++) begin
      #2;
      check($sformatf("rs_a_v1_c%0d", k), 16'(v1), 16'(k >= 2));
      check($sformatf("rs_a_v3_c%0d", k), 16'(v3), 16'(k >= 4));
      if (k == 4) check("rs_a_d3", dout3, 16'hAA34);
      cyc();
    end
    addr = 16'h0003;
    for (int k = 1; k <= 4; k++) begin
      #2;
      check($sformatf("rs_b_v3_c%0d", k), 16'(v3), 16'(k >= 4));
      if (k == 4) check("rs_b_d3", dout3, 16'hBEEF);
      cyc();
    end
    idle();
    cyc();

    // Reset mid-read.
    ce = 1'b0; we = 1'b1; oe = 1'b0; addr = 16'h0003;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    #2;
    check("rst_rd_v1", 16'(v1), 16'h0);
    check("rst_rd_d1", dout1, 16'h0000);
    check("rst_rd_hex", hex1, 16'h0000);
    cyc();
    #2;
    check("rst_rd_again_v1", 16'(v1), 16'h1);
    check("rst_rd_again_d1", dout1, 16'hBEEF);
    idle();
    cyc();

    // Reset mid-write aborts the write.
    ce = 1'b0; we = 1'b0; oe = 1'b1; addr = 16'h0003; din = 16'hDEAD; rst = 1'b0;
    cyc();
    rst = 1'b1;
    idle();
    cyc();
    rd(16'h0003, 4);
    check_both("rst_wr_abort", 16'hBEEF);

    // WE and OE both low: write wins, valid drops.
    wr(16'h0030, 16'h1111, 1'b0, 1'b0);
    ce = 1'b0; we = 1'b1; oe = 1'b0; addr = 16'h0030;
    cyc();
    we = 1'b0; din = 16'hC0DE;
    #2;
    check("we_oe_v1", 16'(v1), 16'h0);
    cyc();
    idle();
    cyc();
    rd(16'h0030, 4);
    check_both("we_oe_write", 16'hC0DE);

    // Write immediately followed by read of the same address.
    ce = 1'b0; we = 1'b0; oe = 1'b1; addr = 16'h0040; din = 16'h4444;
    cyc();
    we = 1'b1; oe = 1'b0;
    repeat (5) cyc();
    #2;
    check("wr_then_rd_d1", dout1, 16'h4444);
    check("wr_then_rd_v1", 16'(v1), 16'h1);
    check("wr_then_rd_d3", dout3, 16'h4444);
    check("wr_then_rd_v3", 16'(v3), 16'h1);
    idle();
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
